// File: rtl/fpu_seq.sv
// fpu_seq: single-issue sequencer that feeds one operation at a time to an external FPU
//
// Optional feature: define FPU_SEQ_ILLEGAL_FLAG_EN to add output out_illegal.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         operation handshake (in_a, in_b, in_op, in_tag)
//   fpu_a, fpu_b, fpu_opcode  registered operands/opcode presented to the FPU
//   fpu_result                result returned by the FPU
//   out_valid/out_ready       result handshake (out_result, out_tag)
//   out_illegal               captured opcode was illegal (FPU_SEQ_ILLEGAL_FLAG_EN only)
module fpu_seq #(
    parameter int WIDTH   = 24,
    parameter int TAG_W   = 4,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH-1:0] fpu_a,
    output logic [WIDTH-1:0] fpu_b,
    output logic [3:0]       fpu_opcode,
    input  logic [WIDTH-1:0] fpu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
`ifdef FPU_SEQ_ILLEGAL_FLAG_EN
    ,
    output logic             out_illegal
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] OP_MUL = 4'b0011;

    state_t            state, state_n;
    logic [2:0]        cnt;
    logic              issue;
    logic [TAG_W-1:0]  tag_q;
    logic              accept, capture, legal, ill_q;

    // The first EXEC cycle is the FPU issue cycle (operands just registered),
    // so the result can be captured no earlier than the second EXEC cycle.
    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign capture   = (state == EXEC) && !issue && (cnt == 3'd0);
    assign legal     = (fpu_opcode <= 4'd6) || (fpu_opcode >= 4'd8 && fpu_opcode <= 4'd10);
    assign out_valid = (state == DONE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? EXEC : IDLE;
            EXEC:    state_n = capture ? DONE : EXEC;
            DONE:    state_n = accept ? EXEC : (out_ready ? IDLE : DONE);
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            issue      <= 1'b0;
            fpu_a      <= '0;
            fpu_b      <= '0;
            fpu_opcode <= '0;
            tag_q      <= '0;
            out_result <= '0;
            out_tag    <= '0;
            ill_q      <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                fpu_a      <= in_a;
                fpu_b      <= in_b;
                fpu_opcode <= in_op;
                tag_q      <= in_tag;
                issue      <= 1'b1;
                cnt        <= (in_op == OP_MUL) ? 3'(MUL_LAT) : 3'd0;
            end else if (state == EXEC) begin
                issue <= 1'b0;
                if (!issue && cnt != 3'd0)
                    cnt <= cnt - 3'd1;
            end
            // Illegal opcodes never expose whatever the FPU drove.
            if (capture) begin
                out_result <= legal ? fpu_result : '0;
                out_tag    <= tag_q;
                ill_q      <= !legal;
            end
        end
    end

`ifdef FPU_SEQ_ILLEGAL_FLAG_EN
    assign out_illegal = out_valid && ill_q;
`else
    logic unused_ill;
    assign unused_ill = ill_q;
`endif

endmodule

// File: tb/tb_fpu_seq.sv
// tb_fpu_seq: randomized self-checking bench for fpu_seq with a transaction-level reference model
module tb_fpu_seq;
    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_a = '0, in_b = '0;
    logic [3:0]  in_op = '0;
    logic [3:0]  in_tag = '0;
    logic [23:0] fpu_a, fpu_b, fpu_result;
    logic [3:0]  fpu_opcode;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_result;
    logic [3:0]  out_tag;
`ifdef FPU_SEQ_ILLEGAL_FLAG_EN
    logic        out_illegal;
`endif

    int checks = 0, failures = 0, cyc = 0;
    bit rnd = 0;

    typedef struct {
        logic [23:0] res;
        logic [3:0]  tag;
        logic        ill;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit busy = 0, prev_v = 0, prev_ret = 0;
    logic [23:0] last_a = '0, last_b = '0;
    logic [3:0]  last_op = '0;

    fpu_seq #(.WIDTH(24), .TAG_W(4), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode), .fpu_result(fpu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
`ifdef FPU_SEQ_ILLEGAL_FLAG_EN
        , .out_illegal(out_illegal)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural FPU: bit 23 is the sign, so abs clears it and neg flips it.
    function automatic logic [23:0] fpu_fn(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b);
        case (op)
            4'd0:    return 24'(a + b);
            4'd1:    return 24'(a - b);
            4'd2:    return a ^ b;
            4'd3:    return 24'(a * b);
            4'd4:    return a & b;
            4'd5:    return a & 24'h7FFFFF;
            4'd6:    return a ^ 24'h800000;
            4'd8:    return a | b;
            4'd9:    return b;
            4'd10:   return a;
            default: return ~a;
        endcase
    endfunction

    assign fpu_result = fpu_fn(fpu_opcode, fpu_a, fpu_b);

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: every accepted op becomes one expected result with a due cycle.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            busy = 0; prev_v = 0; prev_ret = 0;
            last_a = '0; last_b = '0; last_op = '0;
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_result", 32'(out_result), 32'd0);
            chk("rst_out_tag", 32'(out_tag), 32'd0);
            chk("rst_fpu_a", 32'(fpu_a), 32'd0);
            chk("rst_fpu_b", 32'(fpu_b), 32'd0);
            chk("rst_fpu_opcode", 32'(fpu_opcode), 32'd0);
`ifdef FPU_SEQ_ILLEGAL_FLAG_EN
            chk("rst_out_illegal", 32'(out_illegal), 32'd0);
`endif
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!busy || (out_valid && out_ready)));
            chk("fpu_a_hold", 32'(fpu_a), 32'(last_a));
            chk("fpu_b_hold", 32'(fpu_b), 32'(last_b));
            chk("fpu_op_hold", 32'(fpu_opcode), 32'(last_op));
            if (prev_ret) chk("valid_fall", 32'(out_valid), 32'd0);
            if (out_valid && !prev_v) begin
                chk("result_pending", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    cur = q.pop_front();
                    chk("latency", 32'(cyc), 32'(cur.due));
                end
            end
            if (out_valid) begin
                chk("out_result", 32'(out_result), 32'(cur.res));
                chk("out_tag", 32'(out_tag), 32'(cur.tag));
`ifdef FPU_SEQ_ILLEGAL_FLAG_EN
                chk("out_illegal", 32'(out_illegal), 32'(cur.ill));
`endif
            end
            prev_ret = out_valid && out_ready;
            if (prev_ret) busy = 0;
            if (in_valid && in_ready) begin
                busy = 1;
                q.push_back('{res: is_legal(in_op) ? fpu_fn(in_op, in_a, in_b) : 24'd0,
                              tag: in_tag, ill: !is_legal(in_op),
                              due: cyc + 1 + 2 + ((in_op == 4'd3) ? MUL_LAT : 0)});
                last_a = in_a; last_b = in_b; last_op = in_op;
            end
            prev_v = out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b, input logic [3:0] tag);
        bit acc = 0;
        int n = 0;
        in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        while (!acc && n < 60) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        chk("accept_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || q.size() != 0) && n < 200) begin
            if (n > 20) out_ready = 1'b1;
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < 200), 32'd1);
        tick();
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();

        out_ready = 1'b1;
        send(4'b0101, 24'h812345, 24'h0, 4'd3);
        drain();
        chk("abs_value", 32'(cur.res), 32'h012345);

        send(4'b0011, 24'h000123, 24'h000456, 4'd7);
        drain();
        chk("mul_tag", 32'(cur.tag), 32'd7);

        out_ready = 1'b0;
        send(4'b0110, 24'h3F0000, 24'h0, 4'd5);
        repeat (5) tick();
        chk("neg_held_valid", 32'(out_valid), 32'd1);
        chk("neg_held_result", 32'(out_result), 32'hBF0000);
        chk("neg_held_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        drain();

        send(4'd0, 24'h000010, 24'h000020, 4'd1);
        send(4'd1, 24'h000100, 24'h000001, 4'd2);
        drain();
        chk("b2b_last_tag", 32'(cur.tag), 32'd2);

        send(4'b1111, 24'h555555, 24'h0, 4'd9);
        drain();
        chk("illegal_zero", 32'(cur.res), 32'd0);

        send(4'b0011, 24'h000777, 24'h000003, 4'd11);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(in_ready), 32'd1);
        repeat (8) tick();

        rnd = 1;
        for (int i = 0; i < 200; i++) begin
            send(4'($urandom_range(0, 15)), 24'($urandom), 24'($urandom), 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) tick();
        end
        rnd = 0;
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fpu_seq.md
FPU_SEQ -- requirements
Module: fpu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 24: operand and result width in bits.
REQ-002 SHALL have parameter TAG_W, default 4: width of the destination tag carried alongside each operation.
REQ-003 SHALL have parameter MUL_LAT, default 2: number of extra clk cycles the FPU needs to produce a result for opcode 4'b0011, valid range 1..7.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  1  an operation is offered on the in_* ports.
REQ-007 in_ready  output  1  fpu_seq accepts the offered operation on this cycle.
REQ-008 in_a, in_b  input  WIDTH  source operands.
REQ-009 in_op  input  4  FPU opcode.
REQ-010 in_tag  input  TAG_W  destination tag for the operation.
REQ-011 fpu_a, fpu_b  output  WIDTH  registered operands driven to the FPU.
REQ-012 fpu_opcode  output  4  registered opcode driven to the FPU.
REQ-013 fpu_result  input  WIDTH  result returned by the FPU.
REQ-014 out_valid  output  1  a completed result is presented on the out_* ports.
REQ-015 out_ready  input  1  the consumer takes the result on this cycle.
REQ-016 out_result  output  WIDTH  captured result.
REQ-017 out_tag  output  TAG_W  tag of the captured result.

Function
REQ-018 SHALL implement a three-state FSM with states IDLE, EXEC and DONE, and SHALL allow only one operation in flight at a time.
REQ-019 in_ready SHALL equal (state==IDLE) or (state==DONE and out_ready).
REQ-020 An operation SHALL be accepted when in_valid and in_ready are both high; on acceptance the FSM SHALL register in_a, in_b, in_op and in_tag into fpu_a, fpu_b, fpu_opcode and the tag register, and SHALL enter EXEC.
REQ-021 On entry to EXEC, the wait counter SHALL load MUL_LAT when the opcode is 4'b0011 and 0 for every other opcode.
REQ-022 In EXEC, a nonzero counter SHALL decrement once per cycle.
REQ-023 In EXEC, when the counter is 0, the block SHALL capture fpu_result into out_result, SHALL assert out_valid, and SHALL enter DONE.
REQ-024 Latency from the accept edge to the first cycle out_valid is high SHALL be 2 cycles for non-multiply opcodes and 2+MUL_LAT cycles for the multiply opcode.
REQ-025 Legal opcodes SHALL be 0,1,2,3,4,5,6,8,9 and 10.
REQ-026 For any illegal opcode, the block SHALL take the non-multiply latency and SHALL capture out_result as 0, regardless of fpu_result.
REQ-027 In DONE, out_valid, out_result and out_tag SHALL hold stable until out_ready is high.
REQ-028 On a cycle in DONE where out_ready is high and in_valid is low, the FSM SHALL go to IDLE and out_valid SHALL fall on the next cycle.
REQ-029 On a cycle in DONE where out_ready and in_valid are both high, the block SHALL retire the current result and accept the new operation on the same edge, then enter EXEC, with out_valid low on the next cycle.
REQ-030 fpu_a, fpu_b and fpu_opcode SHALL change only on an accept edge.

Reset
REQ-031 While rst is asserted, the FSM SHALL be IDLE and the counter SHALL be 0.
REQ-032 While rst is asserted, out_valid SHALL be 0, in_ready SHALL be 1, and out_result, out_tag, fpu_a, fpu_b and fpu_opcode SHALL be 0.
REQ-033 Assertion of rst during EXEC or DONE SHALL discard the in-flight operation without producing an out_valid pulse for it.

Configuration
REQ-034 With macro FPU_SEQ_ILLEGAL_FLAG_EN defined, the block SHALL add output port out_illegal (1 bit), which is high with out_valid when the captured opcode was illegal, follows the same hold rules as out_result, and resets to 0.
REQ-035 Without FPU_SEQ_ILLEGAL_FLAG_EN, port out_illegal SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-036 The bench SHALL apply in_op=4'b0101, in_a=24'h812345, in_tag=3 with out_ready=1, and SHALL check that out_result=24'h012345 and out_tag=3 with out_valid high exactly 2 cycles after the accept edge.
REQ-037 The bench SHALL apply in_op=4'b0011 with MUL_LAT=2 and tag=7, and SHALL check that out_valid rises 4 cycles after accept, in_ready stays 0 until then, and out_tag=7.
REQ-038 The bench SHALL apply in_op=4'b0110, in_a=24'h3F0000 with out_ready held 0 for 5 cycles, and SHALL check that out_result=24'hBF0000 is held stable with out_valid high and in_ready low until out_ready rises.
REQ-039 The bench SHALL apply back-to-back ops (tags 1 then 2) with in_valid and out_ready held high, and SHALL check that tag 2 is accepted on the same edge that tag 1 retires, and that tag 1 then tag 2 each appear exactly once.
REQ-040 The bench SHALL apply in_op=4'b1111, and SHALL check that out_result=0 after 2 cycles and, with FPU_SEQ_ILLEGAL_FLAG_EN defined, that out_illegal=1.
REQ-041 The bench SHALL assert rst one cycle after accepting a multiply, and SHALL check that out_valid never rises for that operation and in_ready=1 on the first cycle after rst deasserts.
